// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the core load/store unit and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_we;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_type, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_type, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked byte/half/word data memory, one access in flight
// Define DMEM_ERR_CHECK_EN to flag misaligned, out-of-range and illegal-type accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        armed;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  we_q;
  logic [2:0]  type_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          is_store, sign, err;
  logic [1:0]    size, lane;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   rd_word, shifted, load_data, wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid && armed) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // size: 0 byte, 1 half, 2 word; stores take it from req_we, loads from req_type
  assign is_store = (we_q != 2'b00);
  always_comb begin
    size = 2'd2;
    sign = 1'b0;
    if (is_store) begin
      size = we_q - 2'd1;
    end else begin
      case (type_q)
        3'b000:  begin size = 2'd0; sign = 1'b1; end
        3'b001:  begin size = 2'd1; sign = 1'b1; end
        3'b100:  size = 2'd0;
        3'b101:  size = 2'd1;
        default: size = 2'd2;
      endcase
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic type_bad, misalign, range_bad;
  assign type_bad  = !(type_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misalign  = ((size == 2'd1) && addr_q[0]) || ((size == 2'd2) && (addr_q[1:0] != 2'b00));
  assign range_bad = ((addr_q >> (AW + 2)) != 32'd0);
  assign err       = misalign || range_bad || (!is_store && type_bad);
  assign lane      = addr_q[1:0];
`else
  logic unused_addr;
  assign unused_addr = ^addr_q[31:AW+2];
  assign err         = 1'b0;
  assign lane        = (size == 2'd2) ? 2'b00 : (size == 2'd1) ? {addr_q[1], 1'b0} : addr_q[1:0];
`endif

  assign idx     = addr_q[AW+1:2];
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    case (size)
      2'd0:    load_data = sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      2'd1:    load_data = sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    case (size)
      2'd0:    begin be = 4'b0001 << lane; wr_data = {4{wdata_q[7:0]}};  end
      2'd1:    begin be = 4'b0011 << lane; wr_data = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111;         wr_data = wdata_q;            end
    endcase
  end

  // No reset on the array: contents survive reset and start undefined
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_store && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      type_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && bus.req_valid && armed) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
        type_q  <= bus.req_type;
      end
      if (state == ACCESS) begin
        rdata_q <= (is_store || err) ? 32'd0 : load_data;
        err_q   <= err;
      end else if (state == RESP && bus.rsp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // armed keeps req_ready low for the first cycle out of reset
  assign bus.req_ready = armed && (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
